// File: rtl/cwwppb_bus_pkg.sv
// Shared constants for the cwwppb system-bus arbiter: master indices,
// FSM state encoding and the default slave watchdog period.
package cwwppb_bus_pkg;

    localparam int NUM_MASTERS = 3;

    localparam logic [1:0] M_CORE = 2'd0;
    localparam logic [1:0] M_JTAG = 2'd1;
    localparam logic [1:0] M_UART = 2'd2;

    localparam int DEFAULT_TIMEOUT = 255;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/cwwppb_prio_enc.sv
// Combinational 3-to-2 fixed-priority encoder: the highest set request bit
// wins; valid_o flags that at least one request is present.
module cwwppb_prio_enc
    import cwwppb_bus_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] req_i,
    output logic [1:0]             idx_o,
    output logic                   valid_o
);

    always_comb begin
        idx_o = M_CORE;
        if (req_i[M_UART]) begin
            idx_o = M_UART;
        end else if (req_i[M_JTAG]) begin
            idx_o = M_JTAG;
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/cwwppb_bus_arbiter.sv
// Three-master fixed-priority arbiter for the cwwppb system bus with a slave
// watchdog and a core stall request while a debug master owns the bus.
module cwwppb_bus_arbiter
    import cwwppb_bus_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_MASTERS-1:0]        m_req,
    input  logic [NUM_MASTERS-1:0]        m_we,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
    output logic [DATA_W-1:0]             m_rdata,
    output logic [NUM_MASTERS-1:0]        m_ack,
    output logic                          m_err,
    output logic                          s_req,
    output logic                          s_we,
    output logic [ADDR_W-1:0]             s_addr,
    output logic [DATA_W-1:0]             s_wdata,
    input  logic [DATA_W-1:0]             s_rdata,
    input  logic                          s_ack,
    output logic [1:0]                    grant,
    output logic                          busy,
    output logic                          hold_core
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT);

    state_t           state_q;
    logic [1:0]       grant_q;
    logic [CNT_W-1:0] cnt_q;

    logic [1:0]        pick_idx;
    logic              pick_vld;
    logic              is_busy;
    logic              sel_req;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              ack_hit;
    logic              tmo_hit;
    logic              abort_hit;

    cwwppb_prio_enc u_prio_enc (
        .req_i   (m_req),
        .idx_o   (pick_idx),
        .valid_o (pick_vld)
    );

    assign is_busy = (state_q == ST_BUSY);

    always_comb begin
        sel_req   = m_req[0];
        sel_we    = m_we[0];
        sel_addr  = m_addr[0 +: ADDR_W];
        sel_wdata = m_wdata[0 +: DATA_W];
        case (grant_q)
            M_JTAG: begin
                sel_req   = m_req[1];
                sel_we    = m_we[1];
                sel_addr  = m_addr[ADDR_W +: ADDR_W];
                sel_wdata = m_wdata[DATA_W +: DATA_W];
            end
            M_UART: begin
                sel_req   = m_req[2];
                sel_we    = m_we[2];
                sel_addr  = m_addr[2*ADDR_W +: ADDR_W];
                sel_wdata = m_wdata[2*DATA_W +: DATA_W];
            end
            default: ;
        endcase
    end

    // A slave ack wins over the watchdog; a withdrawn request ends silently.
    assign ack_hit   = is_busy && s_ack;
    assign tmo_hit   = is_busy && sel_req && !s_ack && (cnt_q == CNT_LAST);
    assign abort_hit = is_busy && !sel_req && !s_ack;

    always_comb begin
        m_ack = '0;
        if (ack_hit || tmo_hit) begin
            m_ack[grant_q] = 1'b1;
        end
    end

    assign m_err     = tmo_hit;
    assign m_rdata   = ack_hit ? s_rdata : '0;
    assign s_req     = is_busy && sel_req;
    assign s_we      = is_busy && sel_we;
    assign s_addr    = is_busy ? sel_addr : '0;
    assign s_wdata   = is_busy ? sel_wdata : '0;
    assign grant     = grant_q;
    assign busy      = is_busy;
    assign hold_core = !rst && (is_busy ? (grant_q != M_CORE)
                                        : (m_req[M_JTAG] || m_req[M_UART]));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= M_CORE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_vld) begin
                        state_q <= ST_BUSY;
                        grant_q <= pick_idx;
                        cnt_q   <= '0;
                    end
                end
                ST_BUSY: begin
                    if (ack_hit || tmo_hit || abort_hit) begin
                        state_q <= ST_IDLE;
                        grant_q <= M_CORE;
                    end else if (cnt_q != CNT_SAT) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= M_CORE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cwwppb_bus_arbiter.sv
// Directed bench for cwwppb_bus_arbiter: a default-timeout instance covers
// arbitration, priority and reset; a TIMEOUT=8 instance covers the watchdog.
module tb_cwwppb_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int W  = 1 + 3 + DW;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    m_req;
    logic [2:0]    m_we;
    logic [3*AW-1:0] m_addr;
    logic [3*DW-1:0] m_wdata;
    logic [DW-1:0] s_rdata;
    logic          s_ack;

    logic [DW-1:0] m_rdata, m_rdata_t8;
    logic [2:0]    m_ack, m_ack_t8;
    logic          m_err, m_err_t8;
    logic          s_req, s_req_t8;
    logic          s_we, s_we_t8;
    logic [AW-1:0] s_addr, s_addr_t8;
    logic [DW-1:0] s_wdata, s_wdata_t8;
    logic [1:0]    grant, grant_t8;
    logic          busy, busy_t8;
    logic          hold_core, hold_core_t8;

    logic          sel_t8 = 1'b0;
    int            checks = 0;
    int            errors = 0;
    logic [W-1:0]  exp_q[$];

    always #5 clk = ~clk;

    cwwppb_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack(m_ack), .m_err(m_err),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ack(s_ack), .grant(grant), .busy(busy),
        .hold_core(hold_core)
    );

    cwwppb_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut_t8 (
        .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata_t8), .m_ack(m_ack_t8), .m_err(m_err_t8),
        .s_req(s_req_t8), .s_we(s_we_t8), .s_addr(s_addr_t8), .s_wdata(s_wdata_t8),
        .s_rdata(s_rdata), .s_ack(s_ack), .grant(grant_t8), .busy(busy_t8),
        .hold_core(hold_core_t8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic drive_m(input int i, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        m_we[i] = we;
        m_addr[i*AW +: AW] = a;
        m_wdata[i*DW +: DW] = d;
    endtask

    // Scoreboard: every completion pulse must match the oldest expectation;
    // outside a completion the response outputs must be all zero.
    always @(negedge clk) begin
        logic [W-1:0] obs;
        logic [W-1:0] e;
        obs = sel_t8 ? {m_err_t8, m_ack_t8, m_rdata_t8} : {m_err, m_ack, m_rdata};
        if (obs[DW +: 3] != 3'b000) begin
            if (exp_q.size() == 0) begin
                chk("sb_spurious_ack", 64'(obs), 64'(0));
            end else begin
                e = exp_q.pop_front();
                chk("sb_ack", 64'(obs), 64'(e));
            end
        end else begin
            chk("sb_idle_resp", 64'(obs), 64'(0));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0;
        s_rdata = '0; s_ack = 1'b0;
        #3;
        chk("rst_sreq", s_req, 0);
        chk("rst_ack", m_ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_hold", hold_core, 0);
        cyc(); cyc();
        rst = 1'b0;

        // 1: core-only read, slave acks two cycles after s_req
        cyc(); drive_m(0, 1'b0, 32'h1000_0004, '0); m_req = 3'b001;
        smp(); chk("t1_idle_sreq", s_req, 0); chk("t1_idle_hold", hold_core, 0);
        cyc(); smp();
        chk("t1_sreq", s_req, 1); chk("t1_addr", s_addr, 32'h1000_0004);
        chk("t1_we", s_we, 0); chk("t1_hold_busy", hold_core, 0);
        cyc(); smp(); chk("t1_hold_wait", hold_core, 0);
        cyc(); s_ack = 1'b1; s_rdata = 32'hDEAD_BEEF;
        exp_q.push_back({1'b0, 3'b001, 32'hDEAD_BEEF});
        smp(); chk("t1_hold_ack", hold_core, 0); chk("t1_busy_ack", busy, 1);
        cyc(); m_req = '0; s_ack = 1'b0; s_rdata = '0;
        smp(); chk("t1_busy_fall", busy, 0);

        // 2: simultaneous requests served 2, 1, 0 with one IDLE cycle between
        cyc(); drive_m(1, 1'b0, 32'h0000_0100, '0); drive_m(2, 1'b0, 32'h0000_0200, '0);
        m_req = 3'b111;
        smp(); chk("t2_hold_idle0", hold_core, 1); chk("t2_sreq_idle0", s_req, 0);
        cyc(); s_ack = 1'b1; s_rdata = 32'h0000_0022;
        exp_q.push_back({1'b0, 3'b100, 32'h0000_0022});
        smp(); chk("t2_grant2", grant, 2); chk("t2_hold_g2", hold_core, 1);
        chk("t2_addr_g2", s_addr, 32'h0000_0200);
        cyc(); m_req = 3'b011; s_ack = 1'b0;
        smp(); chk("t2_idle1_busy", busy, 0); chk("t2_idle1_grant", grant, 0);
        chk("t2_hold_idle1", hold_core, 1);
        cyc(); s_ack = 1'b1; s_rdata = 32'h0000_0011;
        exp_q.push_back({1'b0, 3'b010, 32'h0000_0011});
        smp(); chk("t2_grant1", grant, 1); chk("t2_hold_g1", hold_core, 1);
        cyc(); m_req = 3'b001; s_ack = 1'b0;
        smp(); chk("t2_idle2_busy", busy, 0); chk("t2_hold_idle2", hold_core, 0);
        cyc(); s_ack = 1'b1; s_rdata = 32'h0000_0055;
        exp_q.push_back({1'b0, 3'b001, 32'h0000_0055});
        smp(); chk("t2_grant0", grant, 0); chk("t2_busy_g0", busy, 1);
        chk("t2_hold_g0", hold_core, 0);
        cyc(); m_req = '0; s_ack = 1'b0; s_rdata = '0;
        smp(); chk("t2_end_busy", busy, 0);

        // 3: M0 write, slave ack after 10 cycles, M2 arrives mid-transaction
        cyc(); drive_m(0, 1'b1, 32'h2000_0000, 32'h0000_00A5);
        drive_m(2, 1'b0, 32'h3000_0000, '0); m_req = 3'b001;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            if (k == 3) m_req = 3'b101;
            if (k == 10) begin
                s_ack = 1'b1;
                exp_q.push_back({1'b0, 3'b001, 32'h0000_0000});
            end
            smp();
            chk("t3_addr_hold", s_addr, 32'h2000_0000);
            chk("t3_grant_hold", grant, 0);
            if (k == 1) begin
                chk("t3_we", s_we, 1);
                chk("t3_wdata", s_wdata, 32'h0000_00A5);
            end
        end
        cyc(); m_req = 3'b100; s_ack = 1'b0;
        smp(); chk("t3_idle_busy", busy, 0); chk("t3_idle_hold", hold_core, 1);
        cyc(); s_ack = 1'b1; s_rdata = 32'h0000_0077;
        exp_q.push_back({1'b0, 3'b100, 32'h0000_0077});
        smp(); chk("t3_grant2", grant, 2); chk("t3_addr2", s_addr, 32'h3000_0000);
        chk("t3_we2", s_we, 0);
        cyc(); m_req = '0; s_ack = 1'b0; s_rdata = '0;
        cyc(); cyc();
        smp(); chk("t3_t8_idle", busy_t8, 0); chk("t3_main_idle", busy, 0);

        // 4: TIMEOUT=8, no slave ack; abort lands in the 8th cycle of s_req
        cyc(); sel_t8 = 1'b1; drive_m(1, 1'b0, 32'h4000_0010, '0); m_req = 3'b010;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            if (k == 8) exp_q.push_back({1'b1, 3'b010, 32'h0000_0000});
            smp();
            chk("t4_sreq", s_req_t8, 1);
            chk("t4_ack", m_ack_t8, (k == 8) ? 3'b010 : 3'b000);
        end
        cyc(); m_req = '0;
        smp(); chk("t4_sreq_drop", s_req_t8, 0); chk("t4_busy_drop", busy_t8, 0);

        // 5: slave ack in the same cycle the watchdog would fire
        cyc(); m_req = 3'b010;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            if (k == 8) begin
                s_ack = 1'b1; s_rdata = 32'h1234_5678;
                exp_q.push_back({1'b0, 3'b010, 32'h1234_5678});
            end
            smp();
            if (k == 8) begin
                chk("t5_err", m_err_t8, 0);
                chk("t5_rdata", m_rdata_t8, 32'h1234_5678);
            end
        end
        cyc(); m_req = '0; s_ack = 1'b0; s_rdata = '0;
        cyc(); sel_t8 = 1'b0;
        smp(); chk("t5_main_idle", busy, 0);

        // 6: asynchronous reset while M2 owns the bus
        cyc(); drive_m(2, 1'b1, 32'h5000_0000, 32'h0000_0099); m_req = 3'b100;
        cyc(); smp();
        chk("t6_grant2", grant, 2); chk("t6_busy", busy, 1); chk("t6_hold", hold_core, 1);
        #2; rst = 1'b1; #1;
        chk("t6_rst_sreq", s_req, 0); chk("t6_rst_ack", m_ack, 0);
        chk("t6_rst_busy", busy, 0); chk("t6_rst_grant", grant, 0);
        chk("t6_rst_hold", hold_core, 0);
        cyc(); rst = 1'b0;
        smp(); chk("t6_post_busy", busy, 0); chk("t6_post_sreq", s_req, 0);
        chk("t6_post_hold", hold_core, 1);
        cyc(); s_ack = 1'b1; s_rdata = 32'hCAFE_F00D;
        exp_q.push_back({1'b0, 3'b100, 32'hCAFE_F00D});
        smp(); chk("t6_regrant", grant, 2); chk("t6_we", s_we, 1);
        chk("t6_wdata", s_wdata, 32'h0000_0099);
        cyc(); m_req = '0; s_ack = 1'b0; s_rdata = '0;
        cyc(); cyc();
        smp(); chk("sb_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cwwppb_bus_arbiter.md
Name: cwwppb_bus_arbiter

Overview:
Shares the SoC's single system bus between three masters: core load/store port (M0), JTAG debug module (M1) and UART debug loader (M2).
- Fixed priority M2 > M1 > M0; each granted transaction is held until the slave acks.
- Watchdog aborts hung slave accesses.
- Sits between cwwppb core / jtag_dm / uart_debug and the address decoder feeding ROM, RAM and peripherals.
- Drives hold_core so the core pipeline stalls while a debug master owns the bus.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 255, cycles in BUSY without s_ack before abort (1..65535)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
m_req  in  3  per-master request, bit i = master i; held high until m_ack[i]
m_we  in  3  per-master write enable
m_addr  in  3*ADDR_W  packed addresses, master i at [i*ADDR_W +: ADDR_W]
m_wdata  in  3*DATA_W  packed write data, same packing
m_rdata  out  DATA_W  read data, valid only in the m_ack cycle
m_ack  out  3  one-hot one-cycle completion pulse to granted master
m_err  out  1  with m_ack: 1 = aborted by timeout
s_req  out  1  request to slave side
s_we  out  1  write enable to slave
s_addr  out  ADDR_W  address to slave
s_wdata  out  DATA_W  write data to slave
s_rdata  in  DATA_W  slave read data, valid with s_ack
s_ack  in  1  slave completion, one cycle
grant  out  2  index of owning master (0 when idle)
busy  out  1  state == BUSY
hold_core  out  1  core stall request

Behaviour:
- Reset (async, rst=1): state=IDLE, grant=0, timeout counter=0; all outputs 0 immediately. A transaction in flight is dropped; no ack is issued.
- States: IDLE, BUSY. Encoded 1 bit, registered.

IDLE:
- If |m_req, latch grant = highest-priority requester (2 > 1 > 0), clear the counter, and go to BUSY on the next edge.
- s_req=0. Arbitration latency: m_req seen at edge N gives s_req=1 from cycle N+1.

BUSY:
- s_req = m_req[grant].
- s_we, s_addr and s_wdata are combinationally muxed from the granted master. Masters hold them stable until ack.
- Counter increments every cycle without s_ack.

BUSY exits:
- s_ack=1: m_ack[grant]=1 and m_rdata=s_rdata in the same cycle (combinational pass-through), m_err=0. Next state IDLE.
- Counter == TIMEOUT-1 and s_ack=0: m_ack[grant]=1, m_err=1, m_rdata=0, s_req dropped next cycle. Next state IDLE.
- m_req[grant] falls before ack (abort): no m_ack pulse, next state IDLE. A late s_ack in IDLE is ignored.
- s_ack and the timeout in the same cycle: s_ack wins, m_err=0.

Re-arbitration:
- Mandatory single IDLE cycle between transactions. There is no back-to-back grant, so a master re-raising req competes fresh.
- Higher-priority requests arriving during BUSY never preempt.

Idle outputs:
- m_rdata=0 and m_ack=0 whenever no ack is issued.
- s_rdata is ignored in IDLE.

hold_core:
- hold_core = (BUSY && grant != 0) || (IDLE && (m_req[1] || m_req[2])), combinational.
- The core treats it as a pipeline hold and does not raise m_req[0] anew while it is asserted.
- M0 may starve under continuous debug traffic; this is intended debug behaviour.

Other rules:
- Counter width is clog2(TIMEOUT+1); it saturates and never wraps.
- grant is an unsigned 2-bit value; value 3 is never produced.

Decomposition:
- Package cwwppb_bus_pkg holds:
  - master index constants M_CORE=0, M_JTAG=1, M_UART=2 and NUM_MASTERS=3;
  - state encoding ST_IDLE/ST_BUSY;
  - the default TIMEOUT constant.
- Sub-module cwwppb_prio_enc: combinational 3-to-2 fixed-priority encoder with a valid output, reused by the interrupt controller.
- The counter and FSM live in the arbiter itself.

Test Plan:
1. Core-only read: m_req=3'b001, addr 0x1000_0004. s_ack two cycles after s_req with s_rdata 0xDEAD_BEEF -> m_ack=3'b001 with m_rdata 0xDEAD_BEEF, m_err=0, hold_core never high, busy falls the following cycle.
2. Simultaneous requests: m_req=3'b111 in one cycle -> grants observed in order 2, 1, 0. Exactly one IDLE cycle between grants. hold_core=1 until the M1 transaction completes, then 0 during the M0 grant.
3. No preemption: M0 writes 0x0000_00A5 to 0x2000_0000 with slave ack delayed 10 cycles; M2 raises req at cycle 3 -> M0 completes first and s_addr never changes mid-transaction. M2 is granted after one IDLE cycle.
4. Timeout: TIMEOUT=8, M1 read with s_ack tied 0 -> m_ack[1]=1, m_err=1, m_rdata=0 exactly 8 cycles after s_req rose. s_req=0 the next cycle.
5. Ack and timeout coincide: s_ack asserted on cycle TIMEOUT-1 with s_rdata 0x1234_5678 -> m_err=0 and m_rdata 0x1234_5678.
6. Reset mid-transaction: rst pulsed while BUSY with grant=2 -> s_req, m_ack, busy and grant are 0 asynchronously with no ack pulse. The first request after rst releases is arbitrated normally.
